fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register, directly upstream of the decode/ALU stages of the pipelined processor. It holds the PC and a word-addressed 16-bit instruction memory that is loaded through a dedicated load port before execution. Each cycle it presents one instruction, with its PC and a valid flag, to decode. It supports stall, flush and branch redirect from later stages.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_imem.sv | 31 +++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, NOP constant and IF/ID bundle for the fetch stage
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP              = 16'h0000;
  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_0020;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc: '0, valid: 1'b0};

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// rtl/fetch_imem.sv - instruction memory: range-checked synchronous write, combinational read
module fetch_imem
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [PC_W-1:0]    i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] r_mem [0:DEPTH-1];
  logic               w_in_range;

  // Loads beyond the array are dropped rather than aliased onto low words.
  assign w_in_range = (i_wr_addr[PC_W-1:ADDR_W] == '0);

  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_in_range) begin
      r_mem[i_wr_addr[ADDR_W-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, fetch priority logic and IF/ID register; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_en,
  input  logic [PC_W-1:0]    i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_stall,
  input  logic               i_redirect_en,
  input  logic [PC_W-1:0]    i_redirect_pc,
  input  logic               i_flush,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        o_fetch_count,
  output logic [31:0]        o_stall_count,
`endif
  output logic [PC_W-1:0]    o_pc_out,
  output logic [INSTR_W-1:0] o_if_id_instr,
  output logic [PC_W-1:0]    o_if_id_pc,
  output logic               o_if_id_valid
);

  logic [PC_W-1:0]    r_pc;
  if_id_t             r_if_id;
  logic [INSTR_W-1:0] w_fetch_word;
  logic [PC_W-1:0]    w_pc_next;

  fetch_imem #(
    .ADDR_W (ADDR_W)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_load_en),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    .i_rd_addr (r_pc[ADDR_W-1:0]),
    .o_rd_data (w_fetch_word)
  );

  assign w_pc_next = r_pc + 1'b1;

  // Load outranks redirect so a program can be written with the pipeline frozen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc    <= RESET_PC;
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_load_en) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_redirect_en) begin
      r_pc    <= i_redirect_pc;
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_flush) begin
      r_if_id <= IF_ID_BUBBLE;
      if (!i_stall) begin
        r_pc <= w_pc_next;
      end
    end else if (!i_stall) begin
      r_pc    <= w_pc_next;
      r_if_id <= '{instr: w_fetch_word, pc: r_pc, valid: 1'b1};
    end
  end

  assign o_pc_out      = r_pc;
  assign o_if_id_instr = r_if_id.instr;
  assign o_if_id_pc    = r_if_id.pc;
  assign o_if_id_valid = r_if_id.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_fetch_event;
  logic        w_stall_event;

  assign w_fetch_event = !i_load_en && !i_redirect_en && !i_flush && !i_stall;
  assign w_stall_event = i_stall && !i_redirect_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_fetch_event) begin
        r_fetch_count <= sat_inc32(r_fetch_count);
      end
      if (w_stall_event) begin
        r_stall_count <= sat_inc32(r_stall_count);
      end
    end
  end

  assign o_fetch_count = r_fetch_count;
  assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, load_en, stall, redirect_en, flush;
  logic [31:0] load_addr, redirect_pc;
  logic [15:0] load_data;
  logic [31:0] pc_out, if_id_pc;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
  logic [31:0] m_fcnt, m_scnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_mem [0:1023];
  logic [31:0] m_pc    = 32'h0;
  logic [15:0] m_instr = 16'h0;
  logic [31:0] m_ipc   = 32'h0;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_load_en     (load_en),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .i_stall       (stall),
    .i_redirect_en (redirect_en),
    .i_redirect_pc (redirect_pc),
    .i_flush       (flush),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_count (fetch_count),
    .o_stall_count (stall_count),
`endif
    .o_pc_out      (pc_out),
    .o_if_id_instr (if_id_instr),
    .o_if_id_pc    (if_id_pc),
    .o_if_id_valid (if_id_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic le, input logic [31:0] la, input logic [15:0] ld,
                       input logic st, input logic re, input logic [31:0] rp, input logic fl);
    reset = rst; load_en = le; load_addr = la; load_data = ld;
    stall = st; redirect_en = re; redirect_pc = rp; flush = fl;
  endtask

  // Model: one edge of the fetch stage, applied from the priority list with the pre-edge state.
  task automatic tick();
    logic [15:0] word_at_pc;
    @(posedge clk);
    word_at_pc = m_mem[m_pc % 1024];
    if (load_en && load_addr < 1024) m_mem[load_addr] = load_data;
`ifdef FETCH_PERF_CNT_EN
    if (reset) begin
      m_fcnt = 0; m_scnt = 0;
    end else begin
      if (!load_en && !redirect_en && !flush && !stall && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      if (stall && !redirect_en && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
`endif
    if (reset) begin
      m_pc = 32'h20; m_valid = 0; m_instr = 16'h0; m_ipc = 0;
    end else if (load_en) begin
      m_valid = 0; m_instr = 16'h0;
    end else if (redirect_en) begin
      m_pc = redirect_pc; m_valid = 0; m_instr = 16'h0;
    end else if (flush) begin
      m_valid = 0; m_instr = 16'h0;
      if (!stall) m_pc = m_pc + 1;
    end else if (!stall) begin
      m_instr = word_at_pc; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 1;
    end
    #1;
    check("pc_out", pc_out, m_pc);
    check("if_id_valid", if_id_valid, m_valid);
    check("if_id_instr", if_id_instr, m_instr);
    if (m_valid) check("if_id_pc", if_id_pc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_fcnt);
    check("stall_count", stall_count, m_scnt);
`endif
  endtask

  task automatic expect_ifid(input string tag, input logic [15:0] ins, input logic [31:0] pc, input logic v);
    check({tag, "_instr"}, if_id_instr, ins);
    check({tag, "_valid"}, if_id_valid, v);
    if (v) check({tag, "_pc"}, if_id_pc, pc);
  endtask

  task automatic run_program_head(input string tag);
    tick(); expect_ifid({tag, "_f0"}, 16'h65BF, 32'h20, 1'b1);
    tick(); expect_ifid({tag, "_f1"}, 16'h25BF, 32'h21, 1'b1);
    tick(); expect_ifid({tag, "_f2"}, 16'h65BF, 32'h22, 1'b1);
  endtask

  initial begin
    logic [15:0] mem0;
    logic [15:0] mem_top;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // Fill the whole memory under reset so every later fetch has a known word.
    for (int i = 0; i < 1024; i++) begin
      drive(1, 1, i, 16'($urandom), 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 32'h20, 16'h65BF, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h21, 16'h25BF, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h22, 16'h65BF, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("reset_pc", pc_out, 32'h20);
    check("reset_valid", if_id_valid, 1'b0);
    check("reset_instr", if_id_instr, 16'h0000);
    check("reset_ifid_pc", if_id_pc, 32'h0);

    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    expect_ifid("run0", 16'h65BF, 32'h20, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_pc", pc_out, 32'h21);
      expect_ifid("stall_hold", 16'h65BF, 32'h20, 1'b1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    expect_ifid("after_stall", 16'h25BF, 32'h21, 1'b1);
    tick();
    expect_ifid("run2", 16'h65BF, 32'h22, 1'b1);

    drive(0, 0, 0, 0, 1, 1, 32'h20, 0); tick();
    check("redir_pc", pc_out, 32'h20);
    expect_ifid("redir_bubble", 16'h0000, 32'h0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    expect_ifid("redir_fetch", 16'h65BF, 32'h20, 1'b1);
    tick();

    check("pre_flush_pc", pc_out, 32'h22);
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("flush_pc", pc_out, 32'h23);
    expect_ifid("flush", 16'h0000, 32'h0, 1'b0);

    mem0 = m_mem[0];
    drive(0, 1, 32'h400, 16'hFFFF, 0, 0, 0, 0); tick();
    check("oor_pc_hold", pc_out, 32'h23);
    check("oor_valid", if_id_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    expect_ifid("oor_mem0", mem0, 32'h0, 1'b1);

    tick(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("midreset_pc", pc_out, 32'h20);
    check("midreset_valid", if_id_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_program_head("refetch");

    mem_top = m_mem[1023];
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("wrap_pc", pc_out, 32'h0);
    expect_ifid("wrap", mem_top, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] la, rp;
      la = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      case ($urandom_range(0, 2))
        0:       rp = $urandom;
        1:       rp = 32'($urandom_range(0, 1100));
        default: rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, la, 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rp, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
